// File: rtl/pong_pkg.sv
// ============================================================================
// pong_pkg : shared state encoding and the clamped period helper
// Rev 1.0
// ============================================================================
`default_nettype none

package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MOVE_L = 3'd1,
    ST_MOVE_R = 3'd2,
    ST_POINT  = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  // Compare before subtracting so the period can never wrap below the floor.
  function automatic logic [31:0] next_period(input logic [31:0] period,
                                              input logic [31:0] dec,
                                              input logic [31:0] min_p);
    if ((period <= min_p) || ((period - min_p) < dec)) return min_p;
    return period - dec;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pong_match_if.sv
// ============================================================================
// pong_match_if : button inputs and game/display outputs of pong_match
// Rev 1.0
// ============================================================================
`default_nettype none

interface pong_match_if #(
  parameter int POS_W   = 4,
  parameter int SCORE_W = 4
);
  logic               p1;
  logic               p2;
  logic               serve_sel;
  logic               to_idle;
  logic [2:0]         state;
  logic [POS_W-1:0]   pos;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic               point1;
  logic               point2;
  logic               win1;
  logic               win2;
  logic               err;

  modport master (
    output p1, p2, serve_sel, to_idle,
    input  state, pos, score1, score2, point1, point2, win1, win2, err
  );

  modport slave (
    input  p1, p2, serve_sel, to_idle,
    output state, pos, score1, score2, point1, point2, win1, win2, err
  );
endinterface

`default_nettype wire

// File: rtl/pong_btn_cond.sv
// ============================================================================
// pong_btn_cond : 2-flop synchroniser followed by a registered rising edge
// Rev 1.0
// ============================================================================
`default_nettype none

module pong_btn_cond (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_btn,
  output logic      o_pedge
);
  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_pedge;

  // Pipeline resets to "pressed" so a button held through reset yields no edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_s3    <= 1'b1;
      r_pedge <= 1'b0;
    end else begin
      r_s1    <= i_btn;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_pedge <= r_s2 & ~r_s3;
    end
  end

  assign o_pedge = r_pedge;
endmodule

`default_nettype wire

// File: rtl/pong_match.sv
// ============================================================================
// pong_match : two-player LED ping-pong rally, scoring and match control
// Rev 1.0
// ============================================================================
`default_nettype none

module pong_match
  import pong_pkg::*;
#(
  parameter int NPOS      = 8,
  parameter int POS_W     = 4,
  parameter int TICK0     = 819,
  parameter int TICK_DEC  = 102,
  parameter int TICK_MIN  = 205,
  parameter int HIT_ZONE  = 2,
  parameter int SCORE_W   = 4,
  parameter int WIN_SCORE = 7
) (
  input wire logic    clk,
  input wire logic    reset,
  pong_match_if.slave bus
);
  localparam int CNT_W = $clog2(TICK0 + 1);

  localparam logic [POS_W-1:0]   c_pos_max = POS_W'(NPOS);
  localparam logic [POS_W-1:0]   c_pos_min = POS_W'(1);
  localparam logic [POS_W-1:0]   c_zone_r  = POS_W'(NPOS - HIT_ZONE + 1);
  localparam logic [POS_W-1:0]   c_zone_l  = POS_W'(HIT_ZONE);
  localparam logic [CNT_W-1:0]   c_tick0   = CNT_W'(TICK0);
  localparam logic [SCORE_W-1:0] c_win     = SCORE_W'(WIN_SCORE);

  logic w_pedge1;
  logic w_pedge2;

  pong_btn_cond u_btn1 (.clk(clk), .reset(reset), .i_btn(bus.p1), .o_pedge(w_pedge1));
  pong_btn_cond u_btn2 (.clk(clk), .reset(reset), .i_btn(bus.p2), .o_pedge(w_pedge2));

  state_t             r_state,  w_state;
  logic [POS_W-1:0]   r_pos,    w_pos;
  logic [CNT_W-1:0]   r_cnt,    w_cnt;
  logic [CNT_W-1:0]   r_period, w_period;
  logic [SCORE_W-1:0] r_score1, w_score1;
  logic [SCORE_W-1:0] r_score2, w_score2;
  logic               r_point1, w_point1;
  logic               r_point2, w_point2;
  logic               r_win1,   w_win1;
  logic               r_win2,   w_win2;
  logic               r_err,    w_err;
  logic               w_step;
  logic               w_award1;
  logic               w_award2;
  logic [CNT_W-1:0]   w_faster;

  assign w_step   = (r_cnt == (r_period - CNT_W'(1)));
  assign w_faster = CNT_W'(next_period(32'(r_period), 32'(TICK_DEC), 32'(TICK_MIN)));

  always_comb begin
    w_state  = r_state;
    w_pos    = r_pos;
    w_cnt    = r_cnt;
    w_period = r_period;
    w_score1 = r_score1;
    w_score2 = r_score2;
    w_point1 = 1'b0;
    w_point2 = 1'b0;
    w_win1   = r_win1;
    w_win2   = r_win2;
    w_err    = 1'b0;
    w_award1 = 1'b0;
    w_award2 = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!bus.serve_sel) begin
          if (w_pedge1) begin
            w_pos    = c_pos_min;
            w_cnt    = '0;
            w_period = c_tick0;
            w_state  = ST_MOVE_R;
          end
          w_err = w_pedge2;
        end else begin
          if (w_pedge2) begin
            w_pos    = c_pos_max;
            w_cnt    = '0;
            w_period = c_tick0;
            w_state  = ST_MOVE_L;
          end
          w_err = w_pedge1;
        end
      end
      ST_MOVE_R: begin
        if (w_pedge2) begin
          if (r_pos >= c_zone_r) begin
            w_state  = ST_MOVE_L;
            w_cnt    = '0;
            w_period = w_faster;
          end else begin
            w_award1 = 1'b1;
          end
        end else if (w_step) begin
          w_cnt = '0;
          if (r_pos == c_pos_max) w_award1 = 1'b1;
          else                    w_pos    = r_pos + POS_W'(1);
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      ST_MOVE_L: begin
        if (w_pedge1) begin
          if (r_pos <= c_zone_l) begin
            w_state  = ST_MOVE_R;
            w_cnt    = '0;
            w_period = w_faster;
          end else begin
            w_award2 = 1'b1;
          end
        end else if (w_step) begin
          w_cnt = '0;
          if (r_pos == c_pos_min) w_award2 = 1'b1;
          else                    w_pos    = r_pos - POS_W'(1);
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      ST_POINT: begin
        if (bus.to_idle) begin
          w_state  = ST_IDLE;
          w_period = c_tick0;
        end
      end
      ST_OVER: begin
        if (bus.to_idle) begin
          w_state  = ST_IDLE;
          w_period = c_tick0;
          w_pos    = '0;
          w_score1 = '0;
          w_score2 = '0;
          w_win1   = 1'b0;
          w_win2   = 1'b0;
        end
      end
      default: w_state = ST_IDLE;
    endcase

    // A point ends the rally; reaching the winning total ends the match.
    if (w_award1) begin
      w_cnt    = '0;
      w_score1 = r_score1 + SCORE_W'(1);
      w_point1 = 1'b1;
      if (w_score1 == c_win) begin
        w_state = ST_OVER;
        w_win1  = 1'b1;
      end else begin
        w_state = ST_POINT;
      end
    end
    if (w_award2) begin
      w_cnt    = '0;
      w_score2 = r_score2 + SCORE_W'(1);
      w_point2 = 1'b1;
      if (w_score2 == c_win) begin
        w_state = ST_OVER;
        w_win2  = 1'b1;
      end else begin
        w_state = ST_POINT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_pos    <= '0;
      r_cnt    <= '0;
      r_period <= c_tick0;
      r_score1 <= '0;
      r_score2 <= '0;
      r_point1 <= 1'b0;
      r_point2 <= 1'b0;
      r_win1   <= 1'b0;
      r_win2   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_pos    <= w_pos;
      r_cnt    <= w_cnt;
      r_period <= w_period;
      r_score1 <= w_score1;
      r_score2 <= w_score2;
      r_point1 <= w_point1;
      r_point2 <= w_point2;
      r_win1   <= w_win1;
      r_win2   <= w_win2;
      r_err    <= w_err;
    end
  end

  assign bus.state  = r_state;
  assign bus.pos    = r_pos;
  assign bus.score1 = r_score1;
  assign bus.score2 = r_score2;
  assign bus.point1 = r_point1;
  assign bus.point2 = r_point2;
  assign bus.win1   = r_win1;
  assign bus.win2   = r_win2;
  assign bus.err    = r_err;
endmodule

`default_nettype wire

// File: tb/tb_pong_match.sv
// ============================================================================
// tb_pong_match : directed scenarios for pong_match with hand-derived timing
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pong_match;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  pong_match_if #(.POS_W(4), .SCORE_W(4)) bus ();

  pong_match #(
    .NPOS(8), .POS_W(4), .TICK0(4), .TICK_DEC(1), .TICK_MIN(2),
    .HIT_ZONE(2), .SCORE_W(4), .WIN_SCORE(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press1();
    bus.p1 = 1'b1; tick(1); bus.p1 = 1'b0;
  endtask

  task automatic press2();
    bus.p2 = 1'b1; tick(1); bus.p2 = 1'b0;
  endtask

  task automatic go_idle();
    bus.to_idle = 1'b1; tick(1); bus.to_idle = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.p1 = 1'b0; bus.p2 = 1'b0; bus.serve_sel = 1'b0; bus.to_idle = 1'b0;
    tick(2);
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d want 0", bus.state); end
    checks++; if (bus.pos !== 4'd0) begin errors++; $display("FAIL rst_pos got %0d want 0", bus.pos); end
    checks++; if ({bus.score1, bus.score2} !== 8'd0) begin errors++; $display("FAIL rst_scores got %0d/%0d want 0/0", bus.score1, bus.score2); end
    checks++; if ({bus.point1, bus.point2, bus.win1, bus.win2, bus.err} !== 5'd0) begin errors++; $display("FAIL rst_flags got %b want 00000", {bus.point1, bus.point2, bus.win1, bus.win2, bus.err}); end
    reset = 1'b0;
    tick(2);
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL rst_release_state got %0d want 0", bus.state); end
  endtask

  task automatic test_illegal_serve();
    bus.serve_sel = 1'b0;
    press2(); tick(3);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL ill_err got %b want 1", bus.err); end
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL ill_state got %0d want 0", bus.state); end
    checks++; if (bus.pos !== 4'd0) begin errors++; $display("FAIL ill_pos got %0d want 0", bus.pos); end
    tick(1);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL ill_err_pulse got %b want 0", bus.err); end
  endtask

  task automatic test_serve_miss();
    bus.serve_sel = 1'b0;
    press1(); tick(3);
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL srv_state got %0d want 2", bus.state); end
    checks++; if (bus.pos !== 4'd1) begin errors++; $display("FAIL srv_pos got %0d want 1", bus.pos); end
    tick(28);
    checks++; if (bus.pos !== 4'd8) begin errors++; $display("FAIL srv_pos_end got %0d want 8", bus.pos); end
    tick(3);
    checks++; if (bus.point1 !== 1'b0 || bus.state !== 3'd2) begin errors++; $display("FAIL srv_early_point got pt=%b st=%0d want 0/2", bus.point1, bus.state); end
    tick(1);
    checks++; if (bus.point1 !== 1'b1) begin errors++; $display("FAIL srv_point1 got %b want 1", bus.point1); end
    checks++; if (bus.score1 !== 4'd1 || bus.score2 !== 4'd0) begin errors++; $display("FAIL srv_score got %0d/%0d want 1/0", bus.score1, bus.score2); end
    checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL srv_point_state got %0d want 3", bus.state); end
    tick(1);
    checks++; if (bus.point1 !== 1'b0 || bus.pos !== 4'd8) begin errors++; $display("FAIL srv_hold got pt=%b pos=%0d want 0/8", bus.point1, bus.pos); end
    go_idle();
    checks++; if (bus.state !== 3'd0 || bus.score1 !== 4'd1) begin errors++; $display("FAIL srv_idle got st=%0d s1=%0d want 0/1", bus.state, bus.score1); end
  endtask

  task automatic test_return();
    bus.serve_sel = 1'b0;
    press1(); tick(3);
    tick(24);
    checks++; if (bus.pos !== 4'd7) begin errors++; $display("FAIL ret_pos7 got %0d want 7", bus.pos); end
    press2(); tick(3);
    checks++; if (bus.state !== 3'd1 || bus.pos !== 4'd7) begin errors++; $display("FAIL ret_turn got st=%0d pos=%0d want 1/7", bus.state, bus.pos); end
    tick(2);
    checks++; if (bus.pos !== 4'd7) begin errors++; $display("FAIL ret_p3_hold got %0d want 7", bus.pos); end
    tick(1);
    checks++; if (bus.pos !== 4'd6) begin errors++; $display("FAIL ret_p3_step got %0d want 6", bus.pos); end
    tick(3);
    checks++; if (bus.pos !== 4'd5) begin errors++; $display("FAIL ret_p3_step2 got %0d want 5", bus.pos); end
    tick(9);
    press1(); tick(3);
    checks++; if (bus.state !== 3'd2 || bus.pos !== 4'd1) begin errors++; $display("FAIL ret_p1_turn got st=%0d pos=%0d want 2/1", bus.state, bus.pos); end
    tick(1);
    checks++; if (bus.pos !== 4'd1) begin errors++; $display("FAIL ret_p2_hold got %0d want 1", bus.pos); end
    tick(1);
    checks++; if (bus.pos !== 4'd2) begin errors++; $display("FAIL ret_p2_step got %0d want 2", bus.pos); end
    tick(10);
    checks++; if (bus.pos !== 4'd7) begin errors++; $display("FAIL ret_p2_pos7 got %0d want 7", bus.pos); end
    press2(); tick(3);
    checks++; if (bus.state !== 3'd1 || bus.pos !== 4'd8) begin errors++; $display("FAIL ret_step_tie got st=%0d pos=%0d want 1/8", bus.state, bus.pos); end
    tick(1);
    checks++; if (bus.pos !== 4'd8) begin errors++; $display("FAIL ret_min_hold got %0d want 8", bus.pos); end
    tick(1);
    checks++; if (bus.pos !== 4'd7) begin errors++; $display("FAIL ret_min_step got %0d want 7", bus.pos); end
    tick(13);
    checks++; if (bus.pos !== 4'd1 || bus.point2 !== 1'b0) begin errors++; $display("FAIL ret_l_end got pos=%0d pt2=%b want 1/0", bus.pos, bus.point2); end
    tick(1);
    checks++; if (bus.point2 !== 1'b1 || bus.score2 !== 4'd1 || bus.state !== 3'd3) begin errors++; $display("FAIL ret_miss got pt2=%b s2=%0d st=%0d want 1/1/3", bus.point2, bus.score2, bus.state); end
    go_idle();
  endtask

  task automatic test_early_swing();
    bus.serve_sel = 1'b0;
    press1(); tick(3);
    tick(12);
    checks++; if (bus.pos !== 4'd4) begin errors++; $display("FAIL early_pos4 got %0d want 4", bus.pos); end
    press2(); tick(3);
    checks++; if (bus.point1 !== 1'b1 || bus.score1 !== 4'd2) begin errors++; $display("FAIL early_foul got pt1=%b s1=%0d want 1/2", bus.point1, bus.score1); end
    checks++; if (bus.state !== 3'd3 || bus.pos !== 4'd4) begin errors++; $display("FAIL early_state got st=%0d pos=%0d want 3/4", bus.state, bus.pos); end
    tick(1);
    checks++; if (bus.point1 !== 1'b0 || bus.pos !== 4'd4) begin errors++; $display("FAIL early_hold got pt1=%b pos=%0d want 0/4", bus.point1, bus.pos); end
    go_idle();
  endtask

  task automatic test_async_reset();
    bus.serve_sel = 1'b1;
    press2(); tick(3);
    checks++; if (bus.state !== 3'd1 || bus.pos !== 4'd8) begin errors++; $display("FAIL ar_serve2 got st=%0d pos=%0d want 1/8", bus.state, bus.pos); end
    tick(5);
    checks++; if (bus.state !== 3'd1 || bus.pos !== 4'd7) begin errors++; $display("FAIL ar_mid got st=%0d pos=%0d want 1/7", bus.state, bus.pos); end
    #2; reset = 1'b1; bus.p1 = 1'b1;
    #1;
    checks++; if (bus.state !== 3'd0 || bus.pos !== 4'd0) begin errors++; $display("FAIL ar_immediate got st=%0d pos=%0d want 0/0", bus.state, bus.pos); end
    checks++; if ({bus.score1, bus.score2} !== 8'd0 || {bus.point1, bus.point2, bus.win1, bus.win2, bus.err} !== 5'd0) begin errors++; $display("FAIL ar_clear got s=%0d/%0d flags=%b want 0/0 00000", bus.score1, bus.score2, {bus.point1, bus.point2, bus.win1, bus.win2, bus.err}); end
    tick(2);
    reset = 1'b0; bus.serve_sel = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      checks++; if (bus.state !== 3'd0 || bus.err !== 1'b0) begin errors++; $display("FAIL ar_held_edge cyc%0d got st=%0d err=%b want 0/0", i, bus.state, bus.err); end
    end
    bus.p1 = 1'b0; tick(3);
    press1(); tick(3);
    checks++; if (bus.state !== 3'd2 || bus.pos !== 4'd1) begin errors++; $display("FAIL ar_repress got st=%0d pos=%0d want 2/1", bus.state, bus.pos); end
    reset = 1'b1; tick(1); reset = 1'b0; tick(1);
  endtask

  task automatic test_match_end();
    bus.serve_sel = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      press1(); tick(3);
      press2(); tick(3);
      checks++; if (bus.point1 !== 1'b1 || bus.score1 !== 4'(k)) begin errors++; $display("FAIL match_pt%0d got pt1=%b s1=%0d want 1/%0d", k, bus.point1, bus.score1, k); end
      checks++;
      if (k == 3) begin
        if (bus.state !== 3'd4 || bus.win1 !== 1'b1) begin errors++; $display("FAIL match_win got st=%0d win1=%b want 4/1", bus.state, bus.win1); end
      end else begin
        if (bus.state !== 3'd3 || bus.win1 !== 1'b0) begin errors++; $display("FAIL match_nowin%0d got st=%0d win1=%b want 3/0", k, bus.state, bus.win1); end
        go_idle();
      end
    end
    tick(3);
    checks++; if (bus.state !== 3'd4 || bus.score1 !== 4'd3 || bus.win1 !== 1'b1 || bus.point1 !== 1'b0) begin errors++; $display("FAIL match_hold got st=%0d s1=%0d w1=%b pt1=%b want 4/3/1/0", bus.state, bus.score1, bus.win1, bus.point1); end
    go_idle();
    checks++; if (bus.state !== 3'd0 || bus.score1 !== 4'd0 || bus.win1 !== 1'b0 || bus.pos !== 4'd0) begin errors++; $display("FAIL match_clear got st=%0d s1=%0d w1=%b pos=%0d want 0/0/0/0", bus.state, bus.score1, bus.win1, bus.pos); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_illegal_serve();
    test_serve_miss();
    test_return();
    test_early_swing();
    test_async_reset();
    test_match_end();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
